// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [5:0]            edge_cnt;
    logic [5:0]            prescale_q;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  bit_done;

    // A latched prescale of 0 makes the compare value 63, giving 64-cycle bits.
    assign bit_done = (edge_cnt == prescale_q - 6'd1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            edge_cnt   <= '0;
            prescale_q <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            if (state == IDLE || bit_done)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 6'd1;

            case (state)
                IDLE: begin
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    if (DATA_VALID) begin
                        data_q     <= P_DATA;
                        par_en_q   <= PAR_EN;
                        par_bit_q  <= PAR_TYP ^ (^P_DATA);
                        prescale_q <= prescale;
                        state      <= START;
                        TX_OUT     <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        TX_OUT  <= data_q[0];
                        data_q  <= data_q >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    // data_q shifts right each bit, so data_q[0] is always the next bit due out.
                    if (bit_done) begin
                        if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            TX_OUT  <= data_q[0];
                            data_q  <= data_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - randomized self-checking bench for uart_tx_frame against a frame-level reference model
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic       cap_tx[$];
    int         cap_len;
    bit         cap_to;
    logic [7:0] dist_data;
    logic       dist_pe;
    logic [5:0] dist_p;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
        .TX_OUT(TX_OUT), .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level at cycle `cyc` of a frame (cycle 0 = first cycle busy is high).
    function automatic logic model_level(logic [7:0] d, logic pe, logic pt, int p, int cyc);
        int pp;
        int b;
        pp = (p == 0) ? 64 : p;
        b  = cyc / pp;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe && b == 9) return (($countones(d) % 2) == 1) ^ pt;
        return 1'b1;
    endfunction

    function automatic int model_len(logic pe, int p);
        return ((p == 0) ? 64 : p) * (pe ? 11 : 10);
    endfunction

    // Called at a falling edge; the request is taken at the following rising edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = p; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    // Records TX_OUT for every busy cycle; optionally disturbs the inputs at frame cycle disturb_at.
    task automatic capture(input int disturb_at);
        int n;
        n = 0;
        cap_tx.delete(); cap_len = 0; cap_to = 0;
        while (busy !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        if (busy !== 1'b1) begin cap_to = 1; return; end
        while (busy === 1'b1 && cap_len < 1000) begin
            cap_tx.push_back(TX_OUT);
            if (disturb_at >= 0 && cap_len == disturb_at) begin
                DATA_VALID = 1'b1; P_DATA = dist_data; PAR_EN = dist_pe;
                PAR_TYP = ~PAR_TYP; prescale = dist_p;
            end else if (disturb_at >= 0 && cap_len == disturb_at + 1) begin
                DATA_VALID = 1'b0;
            end
            cap_len++;
            @(negedge CLK);
        end
        if (busy === 1'b1) cap_to = 1;
    endtask

    task automatic test_reset;
        RST = 1'b0; DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic;
        logic [9:0] exp_bits;
        logic       got;
        bit         idle_ok;
        exp_bits = 10'b1101001010;
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        capture(-1);
        total++;
        if (cap_to || cap_len != 80) begin bad++; $display("FAIL basic_len: got %0d want 80", cap_len); end
        for (int k = 0; k < 10; k++) begin
            got = (k * 8 + 4 < cap_len) ? cap_tx[k*8+4] : 1'bx;
            total++;
            if (got !== exp_bits[k]) begin bad++; $display("FAIL basic_bit%0d: got %b want %b", k, got, exp_bits[k]); end
        end
        idle_ok = 1;
        repeat (20) begin
            if (TX_OUT !== 1'b1 || busy !== 1'b0) idle_ok = 0;
            @(negedge CLK);
        end
        total++;
        if (!idle_ok) begin bad++; $display("FAIL basic_idle: got tx/busy not idle want 1/0"); end
    endtask

    task automatic test_parity;
        logic [7:0] d_tab [3];
        logic       pt_tab[3];
        logic       par_tab[3];
        logic       got;
        int         errs;
        d_tab   = '{8'hA5, 8'h01, 8'h01};
        pt_tab  = '{1'b0, 1'b1, 1'b0};
        par_tab = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            send(d_tab[t], 1'b1, pt_tab[t], 6'd16);
            capture(-1);
            total++;
            if (cap_to || cap_len != 176) begin bad++; $display("FAIL parity%0d_len: got %0d want 176", t, cap_len); end
            got = (cap_len > 152) ? cap_tx[152] : 1'bx;
            total++;
            if (got !== par_tab[t]) begin bad++; $display("FAIL parity%0d_bit: got %b want %b", t, got, par_tab[t]); end
            errs = 0;
            for (int i = 0; i < cap_len; i++)
                if (cap_tx[i] !== model_level(d_tab[t], 1'b1, pt_tab[t], 16, i)) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL parity%0d_wave: got %0d bad cycles want 0", t, errs); end
            @(negedge CLK);
        end
    endtask

    task automatic test_ignore;
        int errs;
        bit quiet;
        dist_data = 8'hFF; dist_pe = 1'b1; dist_p = 6'd16;
        send(8'h3C, 1'b0, 1'b0, 6'd8);
        capture(20);
        total++;
        if (cap_to || cap_len != 80) begin bad++; $display("FAIL ignore_len: got %0d want 80", cap_len); end
        errs = 0;
        for (int i = 0; i < cap_len; i++)
            if (cap_tx[i] !== model_level(8'h3C, 1'b0, 1'b0, 8, i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL ignore_wave: got %0d bad cycles want 0", errs); end
        quiet = 1;
        repeat (100) begin
            if (busy !== 1'b0 || TX_OUT !== 1'b1) quiet = 0;
            @(negedge CLK);
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL ignore_no_second: got activity want idle"); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         errs;
        d = 8'($urandom);
        send(d, 1'b0, 1'b0, 6'd8);
        repeat (34) @(negedge CLK);
        total++;
        if (busy !== 1'b1 || TX_OUT !== d[3]) begin
            bad++; $display("FAIL rstmid_pre: got busy=%b tx=%b want 1/%b", busy, TX_OUT, d[3]);
        end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_abort: got tx=%b busy=%b want 1/0", TX_OUT, busy);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle: got tx=%b busy=%b want 1/0", TX_OUT, busy);
        end
        pe = 1'($urandom); pt = 1'($urandom);
        send(8'h55, pe, pt, 6'd8);
        capture(-1);
        total++;
        if (cap_to || cap_len != model_len(pe, 8)) begin
            bad++; $display("FAIL rstmid_len: got %0d want %0d", cap_len, model_len(pe, 8));
        end
        errs = 0;
        for (int i = 0; i < cap_len; i++)
            if (cap_tx[i] !== model_level(8'h55, pe, pt, 8, i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL rstmid_wave: got %0d bad cycles want 0", errs); end
    endtask

    task automatic test_back_to_back;
        int errs;
        P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; DATA_VALID = 1'b1;
        @(negedge CLK);
        for (int f = 0; f < 3; f++) begin
            capture(-1);
            if (f == 2) DATA_VALID = 1'b0;
            total++;
            if (cap_to || cap_len != 80) begin bad++; $display("FAIL b2b%0d_len: got %0d want 80", f, cap_len); end
            errs = 0;
            for (int i = 0; i < cap_len; i++)
                if (cap_tx[i] !== model_level(8'h81, 1'b0, 1'b0, 8, i)) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL b2b%0d_wave: got %0d bad cycles want 0", f, errs); end
            total++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL b2b%0d_gap: got tx=%b busy=%b want 1/0", f, TX_OUT, busy);
            end
            @(negedge CLK);
            if (f < 2) begin
                total++;
                if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL b2b%0d_restart: got tx=%b busy=%b want 0/1", f, TX_OUT, busy);
                end
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
    endtask

    task automatic test_prescale_edges;
        logic [10:0] exp_bits;
        logic        got;
        logic [7:0]  d;
        logic        pe;
        int          errs;
        exp_bits = 11'b11111111110;
        send(8'hFF, 1'b1, 1'b1, 6'd1);
        capture(-1);
        total++;
        if (cap_to || cap_len != 11) begin bad++; $display("FAIL p1_len: got %0d want 11", cap_len); end
        for (int k = 0; k < 11; k++) begin
            got = (k < cap_len) ? cap_tx[k] : 1'bx;
            total++;
            if (got !== exp_bits[k]) begin bad++; $display("FAIL p1_bit%0d: got %b want %b", k, got, exp_bits[k]); end
        end
        @(negedge CLK);
        d = 8'($urandom); pe = 1'($urandom);
        send(d, pe, 1'b0, 6'd0);
        capture(-1);
        total++;
        if (cap_to || cap_len != model_len(pe, 0)) begin
            bad++; $display("FAIL p0_len: got %0d want %0d", cap_len, model_len(pe, 0));
        end
        errs = 0;
        for (int i = 0; i < cap_len; i++)
            if (cap_tx[i] !== model_level(d, pe, 1'b0, 0, i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL p0_wave: got %0d bad cycles want 0", errs); end
        @(negedge CLK);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         p;
        int         errs;
        int         dat;
        for (int t = 0; t < 10; t++) begin
            d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
            p = $urandom_range(1, 20);
            dist_data = 8'($urandom); dist_pe = 1'($urandom); dist_p = 6'($urandom);
            dat = $urandom_range(0, model_len(pe, p) - 3);
            send(d, pe, pt, 6'(p));
            capture((t % 2 == 0) ? dat : -1);
            total++;
            if (cap_to || cap_len != model_len(pe, p)) begin
                bad++; $display("FAIL rand%0d_len: got %0d want %0d", t, cap_len, model_len(pe, p));
            end
            errs = 0;
            for (int i = 0; i < cap_len; i++)
                if (cap_tx[i] !== model_level(d, pe, pt, p, i)) errs++;
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL rand%0d_wave: got %0d bad cycles want 0 (d=%h pe=%b pt=%b p=%0d)", t, errs, d, pe, pt, p);
            end
            repeat ($urandom_range(1, 4)) @(negedge CLK);
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset;
        test_basic;
        test_parity;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_prescale_edges;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
